// File: rtl/mem_access_initiator.sv
// MEM-stage load/store initiator: latches one access from EX, issues a single
// req/ack transaction on the data-memory port, and returns extended load data.
module mem_access_initiator #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_memrd,
    input  logic        ex_memwr,
    input  logic [63:0] ex_addr,
    input  logic [63:0] ex_wdata,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    output logic        stall,
    output logic        wb_valid,
    output logic [63:0] wb_rdata,
    output logic        misalign,
    output logic        timeout_err,
    output logic        dm_req,
    output logic        dm_we,
    output logic [63:0] dm_addr,
    output logic [63:0] dm_wdata,
    output logic [7:0]  dm_wstrb,
    input  logic        dm_ack,
    input  logic [63:0] dm_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t      r_state, w_state;
    logic        r_stall, w_stall;
    logic        r_wb_valid, w_wb_valid;
    logic [63:0] r_wb_rdata, w_wb_rdata;
    logic        r_misalign, w_misalign;
    logic        r_tmo, w_tmo;
    logic        r_dm_req, w_dm_req;
    logic        r_dm_we, w_dm_we;
    logic [63:0] r_dm_addr, w_dm_addr;
    logic [63:0] r_dm_wdata, w_dm_wdata;
    logic [7:0]  r_dm_wstrb, w_dm_wstrb;
    logic [7:0]  r_cnt, w_cnt;
    logic [2:0]  r_off, w_off;
    logic [1:0]  r_size, w_size;
    logic        r_uns, w_uns;

    logic        w_accept;
    logic        w_misal;
    logic [7:0]  w_strb_base;

    // Shift the addressed bytes down to bit 0, keep the sized field, extend it.
    function automatic logic [63:0] fmt_load(input logic [63:0] d, input logic [2:0] off,
                                             input logic [1:0] size, input logic uns);
        logic [63:0]        s;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        logic signed [63:0] r;
        s = d >> {off, 3'b000};
        b = s[7:0];
        h = s[15:0];
        w = s[31:0];
        case (size)
            2'd0:    r = uns ? {56'd0, s[7:0]}  : 64'(b);
            2'd1:    r = uns ? {48'd0, s[15:0]} : 64'(h);
            2'd2:    r = uns ? {32'd0, s[31:0]} : 64'(w);
            default: r = s;
        endcase
        return r;
    endfunction

    assign w_accept = ex_valid & (ex_memrd | ex_memwr);

    always_comb begin
        w_misal     = 1'b0;
        w_strb_base = 8'hFF;
        case (ex_size)
            2'd0: begin w_misal = 1'b0;          w_strb_base = 8'h01; end
            2'd1: begin w_misal = ex_addr[0];    w_strb_base = 8'h03; end
            2'd2: begin w_misal = |ex_addr[1:0]; w_strb_base = 8'h0F; end
            default: begin w_misal = |ex_addr[2:0]; w_strb_base = 8'hFF; end
        endcase
    end

    always_comb begin
        w_state    = r_state;
        w_stall    = 1'b0;
        w_wb_valid = 1'b0;
        w_wb_rdata = 64'd0;
        w_misalign = 1'b0;
        w_tmo      = 1'b0;
        w_dm_req   = r_dm_req;
        w_dm_we    = r_dm_we;
        w_dm_addr  = r_dm_addr;
        w_dm_wdata = r_dm_wdata;
        w_dm_wstrb = r_dm_wstrb;
        w_cnt      = r_cnt;
        w_off      = r_off;
        w_size     = r_size;
        w_uns      = r_uns;
        case (r_state)
            REQ: begin
                if (dm_ack) begin
                    w_state    = RESP;
                    w_dm_req   = 1'b0;
                    w_wb_valid = 1'b1;
                    w_wb_rdata = r_dm_we ? 64'd0 : fmt_load(dm_rdata, r_off, r_size, r_uns);
                end else if (r_cnt == LAST_CNT) begin
                    w_state    = RESP;
                    w_dm_req   = 1'b0;
                    w_wb_valid = 1'b1;
                    w_tmo      = 1'b1;
                end else begin
                    w_cnt   = r_cnt + 8'd1;
                    w_stall = 1'b1;
                end
            end
            default: begin
                // IDLE and RESP both accept; RESP falls back to IDLE otherwise.
                w_state  = IDLE;
                w_dm_req = 1'b0;
                if (w_accept) begin
                    if (w_misal) begin
                        w_state    = RESP;
                        w_wb_valid = 1'b1;
                        w_misalign = 1'b1;
                    end else begin
                        w_state    = REQ;
                        w_stall    = 1'b1;
                        w_dm_req   = 1'b1;
                        w_dm_we    = ex_memwr;
                        w_dm_addr  = {ex_addr[63:3], 3'b000};
                        w_dm_wdata = ex_memwr ? (ex_wdata << {ex_addr[2:0], 3'b000}) : 64'd0;
                        w_dm_wstrb = ex_memwr ? (w_strb_base << ex_addr[2:0]) : 8'd0;
                        w_cnt      = 8'd0;
                        w_off      = ex_addr[2:0];
                        w_size     = ex_size;
                        w_uns      = ex_unsigned;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_stall    <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_rdata <= 64'd0;
            r_misalign <= 1'b0;
            r_tmo      <= 1'b0;
            r_dm_req   <= 1'b0;
            r_dm_we    <= 1'b0;
            r_dm_addr  <= 64'd0;
            r_dm_wdata <= 64'd0;
            r_dm_wstrb <= 8'd0;
            r_cnt      <= 8'd0;
            r_off      <= 3'd0;
            r_size     <= 2'd0;
            r_uns      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_stall    <= w_stall;
            r_wb_valid <= w_wb_valid;
            r_wb_rdata <= w_wb_rdata;
            r_misalign <= w_misalign;
            r_tmo      <= w_tmo;
            r_dm_req   <= w_dm_req;
            r_dm_we    <= w_dm_we;
            r_dm_addr  <= w_dm_addr;
            r_dm_wdata <= w_dm_wdata;
            r_dm_wstrb <= w_dm_wstrb;
            r_cnt      <= w_cnt;
            r_off      <= w_off;
            r_size     <= w_size;
            r_uns      <= w_uns;
        end
    end

    assign stall       = r_stall;
    assign wb_valid    = r_wb_valid;
    assign wb_rdata    = r_wb_rdata;
    assign misalign    = r_misalign;
    assign timeout_err = r_tmo;
    assign dm_req      = r_dm_req;
    assign dm_we       = r_dm_we;
    assign dm_addr     = r_dm_addr;
    assign dm_wdata    = r_dm_wdata;
    assign dm_wstrb    = r_dm_wstrb;

endmodule

// File: tb/tb_mem_access_initiator.sv
// Self-checking bench for mem_access_initiator (built with TIMEOUT=4).
module tb_mem_access_initiator;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0, ex_memrd = 1'b0, ex_memwr = 1'b0, ex_unsigned = 1'b0;
    logic [63:0] ex_addr = '0, ex_wdata = '0;
    logic [1:0]  ex_size = '0;
    logic        stall, wb_valid, misalign, timeout_err, dm_req, dm_we;
    logic [63:0] wb_rdata, dm_addr, dm_wdata;
    logic [7:0]  dm_wstrb;
    logic        dm_ack = 1'b0;
    logic [63:0] dm_rdata = '0;

    int checks = 0;
    int errors = 0;

    mem_access_initiator #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_memrd(ex_memrd), .ex_memwr(ex_memwr),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_size(ex_size), .ex_unsigned(ex_unsigned),
        .stall(stall), .wb_valid(wb_valid), .wb_rdata(wb_rdata), .misalign(misalign),
        .timeout_err(timeout_err), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    // Reference model: byte-level view of the access.
    function automatic logic [63:0] m_load(logic [63:0] d, logic [63:0] a, int sz, bit uns);
        int nb = 1 << sz;
        int off = int'(a[2:0]);
        logic [63:0] v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = d[8*(off+i) +: 8];
        if (!uns && v[8*nb-1]) for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [7:0] m_strb(logic [63:0] a, int sz);
        logic [7:0] s = '0;
        for (int i = 0; i < (1 << sz); i++) s[int'(a[2:0]) + i] = 1'b1;
        return s;
    endfunction

    function automatic bit m_misal(logic [63:0] a, int sz);
        return (a % (64'd1 << sz)) != 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(bit rd, bit wr, logic [63:0] a, logic [63:0] wd, int sz, bit uns);
        ex_valid = 1'b1; ex_memrd = rd; ex_memwr = wr; ex_addr = a;
        ex_wdata = wd; ex_size = 2'(sz); ex_unsigned = uns;
    endtask

    task automatic clear_ex();
        ex_valid = 1'b0; ex_memrd = 1'b0; ex_memwr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_ex(1, 0, 64'h40, 64'h0, 3, 0);
        tick(); tick();
        checks++; if ({stall, wb_valid, misalign, timeout_err, dm_req, dm_we} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b required 000000", {stall, wb_valid, misalign, timeout_err, dm_req, dm_we}); end
        checks++; if ({dm_addr, dm_wdata, dm_wstrb, wb_rdata} !== '0) begin
            errors++; $display("FAIL reset_data: got %h %h %h %h required all 0", dm_addr, dm_wdata, dm_wstrb, wb_rdata); end
        rst = 1'b0;
        clear_ex();
        tick();
    endtask

    task automatic test_dword_load();
        drive_ex(1, 0, 64'h40, 64'hDEAD, 3, 0);
        tick();
        clear_ex();
        checks++; if ({dm_req, dm_we, stall} !== 3'b101) begin
            errors++; $display("FAIL dword_req: got req/we/stall %b required 101", {dm_req, dm_we, stall}); end
        checks++; if (dm_addr !== 64'h40 || dm_wstrb !== 8'h00 || dm_wdata !== 64'h0) begin
            errors++; $display("FAIL dword_port: got addr %h strb %h wdata %h required 40 00 0", dm_addr, dm_wstrb, dm_wdata); end
        dm_ack = 1'b1; dm_rdata = 64'h1122334455667788;
        tick();
        dm_ack = 1'b0;
        checks++; if (wb_valid !== 1'b1 || wb_rdata !== 64'h1122334455667788) begin
            errors++; $display("FAIL dword_data: got valid %b data %h required 1 1122334455667788", wb_valid, wb_rdata); end
        checks++; if ({stall, dm_req, timeout_err, misalign} !== 4'b0) begin
            errors++; $display("FAIL dword_resp_ctrl: got %b required 0000", {stall, dm_req, timeout_err, misalign}); end
        tick();
        checks++; if (wb_valid !== 1'b0) begin
            errors++; $display("FAIL dword_pulse: got wb_valid %b required 0", wb_valid); end
    endtask

    task automatic test_byte_load();
        for (int u = 0; u < 2; u++) begin
            drive_ex(1, 0, 64'h45, 64'h0, 0, u[0]);
            tick();
            clear_ex();
            dm_ack = 1'b1; dm_rdata = 64'h0000800000000000;
            tick();
            dm_ack = 1'b0;
            checks++; if (wb_valid !== 1'b1 || wb_rdata !== (u ? 64'h80 : 64'hFFFFFFFFFFFFFF80)) begin
                errors++; $display("FAIL byte_load_u%0d: got valid %b data %h", u, wb_valid, wb_rdata); end
            tick();
        end
    endtask

    task automatic test_half_store();
        int nvalid = 0;
        drive_ex(0, 1, 64'h106, 64'hBEEF, 1, 0);
        tick();
        clear_ex();
        for (int c = 0; c < 4; c++) begin
            checks++; if (dm_req !== 1'b1 || dm_we !== 1'b1 || dm_addr !== 64'h100 || dm_wstrb !== 8'hC0
                          || dm_wdata !== 64'hBEEF000000000000 || stall !== 1'b1) begin
                errors++; $display("FAIL half_store_hold%0d: got req %b we %b addr %h strb %h wdata %h stall %b",
                                   c, dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata, stall); end
            if (wb_valid) nvalid++;
            dm_ack = (c == 3);
            tick();
        end
        dm_ack = 1'b0;
        checks++; if (wb_valid !== 1'b1 || timeout_err !== 1'b0 || wb_rdata !== 64'h0 || dm_req !== 1'b0) begin
            errors++; $display("FAIL half_store_done: got valid %b tmo %b data %h req %b required 1 0 0 0",
                               wb_valid, timeout_err, wb_rdata, dm_req); end
        nvalid += int'(wb_valid);
        tick();
        nvalid += int'(wb_valid);
        checks++; if (nvalid !== 1) begin
            errors++; $display("FAIL half_store_once: got %0d wb_valid pulses required 1", nvalid); end
    endtask

    task automatic test_misalign();
        drive_ex(1, 0, 64'h2, 64'h0, 2, 0);
        dm_ack = 1'b1; dm_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        clear_ex();
        checks++; if ({misalign, wb_valid, dm_req, stall, timeout_err} !== 5'b11000 || wb_rdata !== 64'h0) begin
            errors++; $display("FAIL misalign_pulse: got mis/val/req/stall/tmo %b data %h required 11000 0",
                               {misalign, wb_valid, dm_req, stall, timeout_err}, wb_rdata); end
        tick();
        dm_ack = 1'b0;
        checks++; if ({misalign, wb_valid, dm_req} !== 3'b000) begin
            errors++; $display("FAIL misalign_after: got %b required 000", {misalign, wb_valid, dm_req}); end
    endtask

    task automatic test_timeout();
        int nreq = 0;
        drive_ex(1, 0, 64'h88, 64'h0, 3, 0);
        tick();
        clear_ex();
        for (int c = 0; c < TMO + 2 && dm_req; c++) begin
            nreq++;
            tick();
        end
        checks++; if (nreq !== TMO) begin
            errors++; $display("FAIL timeout_len: got dm_req high %0d cycles required %0d", nreq, TMO); end
        checks++; if ({timeout_err, wb_valid, stall, dm_req} !== 4'b1100 || wb_rdata !== 64'h0) begin
            errors++; $display("FAIL timeout_pulse: got tmo/val/stall/req %b data %h required 1100 0",
                               {timeout_err, wb_valid, stall, dm_req}, wb_rdata); end
        dm_ack = 1'b1; dm_rdata = 64'h1234;
        tick();
        dm_ack = 1'b0;
        checks++; if ({timeout_err, wb_valid, dm_req} !== 3'b000) begin
            errors++; $display("FAIL timeout_late_ack: got %b required 000", {timeout_err, wb_valid, dm_req}); end
    endtask

    task automatic test_reset_in_req();
        drive_ex(1, 0, 64'h200, 64'h0, 3, 0);
        tick();
        clear_ex();
        rst = 1'b1; dm_ack = 1'b1; dm_rdata = 64'hAAAA;
        tick();
        rst = 1'b0; dm_ack = 1'b0;
        checks++; if ({dm_req, wb_valid, stall} !== 3'b000) begin
            errors++; $display("FAIL rst_in_req: got req/val/stall %b required 000", {dm_req, wb_valid, stall}); end
        tick();
        checks++; if ({dm_req, wb_valid} !== 2'b00) begin
            errors++; $display("FAIL rst_in_req_after: got %b required 00", {dm_req, wb_valid}); end
    endtask

    task automatic test_back_to_back();
        drive_ex(1, 0, 64'h300, 64'h0, 2, 1);
        tick();
        clear_ex();
        dm_ack = 1'b1; dm_rdata = 64'h0000_0000_F000_0001;
        tick();
        dm_ack = 1'b0;
        drive_ex(1, 0, 64'h30C, 64'h0, 2, 0);
        checks++; if (wb_valid !== 1'b1 || wb_rdata !== 64'hF0000001) begin
            errors++; $display("FAIL b2b_first: got valid %b data %h required 1 f0000001", wb_valid, wb_rdata); end
        tick();
        drive_ex(0, 1, 64'h500, 64'h55, 3, 0);
        checks++; if (dm_req !== 1'b1 || dm_addr !== 64'h308 || stall !== 1'b1 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_issue: got req %b addr %h stall %b val %b required 1 308 1 0",
                               dm_req, dm_addr, stall, wb_valid); end
        tick();
        clear_ex();
        checks++; if (dm_we !== 1'b0 || dm_addr !== 64'h308 || dm_wstrb !== 8'h00) begin
            errors++; $display("FAIL b2b_ignore_ex: got we %b addr %h strb %h required 0 308 00", dm_we, dm_addr, dm_wstrb); end
        dm_ack = 1'b1; dm_rdata = 64'h8000_0000_0000_0000;
        tick();
        dm_ack = 1'b0;
        checks++; if (wb_valid !== 1'b1 || wb_rdata !== 64'hFFFFFFFF80000000) begin
            errors++; $display("FAIL b2b_second: got valid %b data %h required 1 ffffffff80000000", wb_valid, wb_rdata); end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            bit rd, wr, uns, tmo;
            int sz, dly;
            logic [63:0] a, wd, rdat, exp_d;
            rd = 1'($urandom); wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            sz = int'($urandom_range(0, 3));
            a = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 1);
            wd = {$urandom, $urandom}; rdat = {$urandom, $urandom};
            uns = 1'($urandom);
            dly = int'($urandom_range(0, 5));
            drive_ex(rd, wr, a, wd, sz, uns);
            tick();
            clear_ex();
            if (m_misal(a, sz)) begin
                checks++; if ({misalign, wb_valid, dm_req} !== 3'b110 || wb_rdata !== 64'h0) begin
                    errors++; $display("FAIL rnd%0d_misal: got mis/val/req %b data %h", n, {misalign, wb_valid, dm_req}, wb_rdata); end
                tick();
                continue;
            end
            for (int c = 0; c < TMO; c++) begin
                checks++; if (dm_req !== 1'b1 || dm_we !== wr || dm_addr !== (a & ~64'h7)
                              || dm_wdata !== (wr ? wd << (8 * a[2:0]) : 64'h0)
                              || dm_wstrb !== (wr ? m_strb(a, sz) : 8'h00)) begin
                    errors++; $display("FAIL rnd%0d_port: got req %b we %b addr %h wdata %h strb %h",
                                       n, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb); end
                dm_ack = (c == dly); dm_rdata = rdat;
                tick();
                dm_ack = 1'b0;
                if (c == dly) break;
            end
            tmo = (dly >= TMO);
            exp_d = (tmo || wr) ? 64'h0 : m_load(rdat, a, sz, uns);
            checks++; if (wb_valid !== 1'b1 || timeout_err !== tmo || wb_rdata !== exp_d || dm_req !== 1'b0) begin
                errors++; $display("FAIL rnd%0d_done: got val %b tmo %b data %h required tmo %b data %h",
                                   n, wb_valid, timeout_err, wb_rdata, tmo, exp_d); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_dword_load();
        test_byte_load();
        test_half_store();
        test_misalign();
        test_timeout();
        test_reset_in_req();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
